// File: rtl/sha256_padder_if.sv
// Handshake bundle between the message word stream, the SHA-256 padder and the
// message-schedule block loader.
interface sha256_padder_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic [1:0]   in_nbytes;
    logic         in_ready;
    logic [511:0] M;
    logic         M_v;
    logic         M_ready;
    logic         M_first;
    logic         M_last;

    // master drives the word stream and accepts blocks; slave is the padder.
    modport master (
        output in_data, in_valid, in_last, in_nbytes, M_ready,
        input  in_ready, M, M_v, M_first, M_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_nbytes, M_ready,
        output in_ready, M, M_v, M_first, M_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 front end: packs big-endian 32-bit message words into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length, and tags first/last blocks.
module sha256_padder (
    input  logic           clk,
    input  logic           rst_n,
    sha256_padder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_PAD,
        ST_EMIT
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  p_reg, p_next;
    logic [60:0] cnt_reg, cnt_next;
    logic        pend80_reg, pend80_next;
    logic        first_pend_reg, first_pend_next;
    logic        last_flag_reg, last_flag_next;
    logic        cont_reg, cont_next;

    logic [31:0]  blk_word [16];
    logic [31:0]  blk_next [16];
    logic [511:0] blk_flat;

    logic [31:0] tail_word;
    logic [2:0]  word_bytes;
    logic [63:0] bit_len;
    logic        fits;

    // Final word: keep the valid bytes and put the marker in the first unused byte.
    always_comb begin
        case (bus.in_nbytes)
            2'd1:    tail_word = {bus.in_data[31:24], 24'h800000};
            2'd2:    tail_word = {bus.in_data[31:16], 16'h8000};
            2'd3:    tail_word = {bus.in_data[31:8], 8'h80};
            default: tail_word = bus.in_data;
        endcase
    end

    assign word_bytes = (bus.in_last && (bus.in_nbytes != 2'd0)) ? {1'b0, bus.in_nbytes} : 3'd4;
    assign bit_len    = {cnt_reg, 3'b000};
    assign fits       = pend80_reg ? (p_reg <= 5'd13) : (p_reg <= 5'd14);

    always_comb begin
        state_next      = state_reg;
        p_next          = p_reg;
        cnt_next        = cnt_reg;
        pend80_next     = pend80_reg;
        first_pend_next = first_pend_reg;
        last_flag_next  = last_flag_reg;
        cont_next       = cont_reg;
        for (int i = 0; i < 16; i++) begin
            blk_next[i] = blk_word[i];
        end

        case (state_reg)
            ST_ACCEPT: begin
                if (bus.in_valid) begin
                    blk_next[p_reg[3:0]] = bus.in_last ? tail_word : bus.in_data;
                    p_next   = p_reg + 5'd1;
                    cnt_next = cnt_reg + 61'(word_bytes);
                    if (bus.in_last) begin
                        pend80_next = (bus.in_nbytes == 2'd0);
                        // A last word that fills the block leaves padding for a continuation block.
                        if (p_reg == 5'd15) begin
                            state_next = ST_EMIT;
                            cont_next  = 1'b1;
                        end else begin
                            state_next = ST_PAD;
                        end
                    end else if (p_reg == 5'd15) begin
                        state_next = ST_EMIT;
                        cont_next  = 1'b0;
                    end
                end
            end

            ST_PAD: begin
                for (int i = 0; i < 16; i++) begin
                    if (5'(i) == p_reg) begin
                        blk_next[i] = pend80_reg ? 32'h8000_0000 : 32'h0;
                    end else if (5'(i) > p_reg) begin
                        blk_next[i] = 32'h0;
                    end
                end
                if (fits) begin
                    blk_next[14]   = bit_len[63:32];
                    blk_next[15]   = bit_len[31:0];
                    last_flag_next = 1'b1;
                    cont_next      = 1'b0;
                end else begin
                    pend80_next = 1'b0;
                    p_next      = 5'd0;
                    cont_next   = 1'b1;
                end
                state_next = ST_EMIT;
            end

            ST_EMIT: begin
                if (bus.M_ready) begin
                    first_pend_next = 1'b0;
                    p_next          = 5'd0;
                    if (last_flag_reg) begin
                        cnt_next        = '0;
                        last_flag_next  = 1'b0;
                        first_pend_next = 1'b1;
                        state_next      = ST_ACCEPT;
                    end else if (cont_reg) begin
                        cont_next  = 1'b0;
                        state_next = ST_PAD;
                    end else begin
                        state_next = ST_ACCEPT;
                    end
                end
            end

            default: begin
                state_next = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_ACCEPT;
            p_reg          <= '0;
            cnt_reg        <= '0;
            pend80_reg     <= 1'b0;
            first_pend_reg <= 1'b1;
            last_flag_reg  <= 1'b0;
            cont_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            p_reg          <= p_next;
            cnt_reg        <= cnt_next;
            pend80_reg     <= pend80_next;
            first_pend_reg <= first_pend_next;
            last_flag_reg  <= last_flag_next;
            cont_reg       <= cont_next;
        end
    end

    // One 32-bit register per block word; word 0 lands in the top of M.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else begin
                    word_reg <= blk_next[gi];
                end
            end

            assign blk_word[gi]                 = word_reg;
            assign blk_flat[511 - 32*gi -: 32]  = word_reg;
        end
    endgenerate

    assign bus.M        = blk_flat;
    assign bus.in_ready = (state_reg == ST_ACCEPT);
    assign bus.M_v      = (state_reg == ST_EMIT);
    assign bus.M_first  = first_pend_reg;
    assign bus.M_last   = last_flag_reg;
endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: table of message lengths, hand-written corner sequences
// and random messages, all checked against a byte-level FIPS 180-4 padding model.
module tb_sha256_padder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha256_padder_if bus ();

    sha256_padder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [511:0] m;
        logic         first;
        logic         last;
    } blk_t;

    typedef struct {
        int          len;
        int          exp_blocks;
        logic [31:0] exp_w15;
        bit          chk_w14;
        logic [31:0] exp_w14;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   mready_mode = 0;
    logic rnd_ready = 1'b1;
    blk_t got[$];
    vec_t vecs[11];

    assign bus.M_ready = (mready_mode == 0) ? 1'b1 : ((mready_mode == 1) ? rnd_ready : 1'b0);

    always begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst_n && bus.M_v && bus.M_ready) got.push_back({bus.M, bus.M_first, bus.M_last});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit big-endian bit length.
    function automatic void pad_model(input logic [7:0] msg[$], output logic [511:0] blks[$]);
        logic [7:0]   b[$];
        logic [63:0]  bitlen;
        logic [511:0] v;
        b = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int i = 7; i >= 0; i--) b.push_back(bitlen[8*i +: 8]);
        blks = {};
        for (int k = 0; k < b.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) v[511 - 8*j -: 8] = b[64*k + j];
            blks.push_back(v);
        end
    endfunction

    function automatic void rand_msg(input int len, output logic [7:0] msg[$]);
        msg = {};
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the word transferred.
    task automatic send_word(input logic [31:0] data, input logic last, input logic [1:0] nb);
        int waited = 0;
        bus.in_data   = data;
        bus.in_last   = last;
        bus.in_nbytes = nb;
        bus.in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) chk_b("in_ready_wait", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_data   = $urandom;
        bus.in_last   = 1'($urandom_range(0, 1));
        bus.in_nbytes = 2'($urandom_range(0, 3));
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit gaps);
        int          nw;
        int          idx;
        logic [31:0] d;
        logic        lst;
        logic [1:0]  nb;
        nw = (msg.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            for (int j = 0; j < 4; j++) begin
                idx = 4*w + j;
                d[31 - 8*j -: 8] = (idx < msg.size()) ? msg[idx] : 8'($urandom_range(0, 255));
            end
            lst = (w == nw - 1);
            nb  = lst ? 2'(msg.size() % 4) : 2'($urandom_range(0, 3));
            send_word(d, lst, nb);
        end
    endtask

    task automatic collect(input int n, output blk_t blks[$]);
        int waited = 0;
        while ((got.size() < n) && (waited < 3000)) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        chk32("block_count", 32'(got.size()), 32'(n));
        blks = got;
        got.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input logic [7:0] msg[$], input bit gaps, output blk_t blks[$]);
        logic [511:0] ref_blks[$];
        pad_model(msg, ref_blks);
        send_msg(msg, gaps);
        collect(ref_blks.size(), blks);
        for (int k = 0; (k < ref_blks.size()) && (k < blks.size()); k++) begin
            chk($sformatf("len%0d_blk%0d_data", msg.size(), k), blks[k].m, ref_blks[k]);
            chk_b($sformatf("len%0d_blk%0d_first", msg.size(), k), blks[k].first, k == 0);
            chk_b($sformatf("len%0d_blk%0d_last", msg.size(), k), blks[k].last, k == ref_blks.size() - 1);
        end
        $display("msg len=%0d blocks=%0d (model %0d)", msg.size(), blks.size(), ref_blks.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_b({tag, "_M_v"},      bus.M_v,      1'b0);
        chk_b({tag, "_in_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_M"},          bus.M,        512'h0);
        chk_b({tag, "_M_first"},  bus.M_first,  1'b1);
        chk_b({tag, "_M_last"},   bus.M_last,   1'b0);
    endtask

    initial begin
        blk_t         blks[$];
        logic [7:0]   msg[$];
        logic [511:0] abc_blk;
        blk_t         cap;
        bit           stable;
        int           waited;

        vecs[0]  = '{3,   1, 32'h0000_0018, 1'b1, 32'h0};
        vecs[1]  = '{55,  1, 32'h0000_01B8, 1'b1, 32'h0};
        vecs[2]  = '{56,  2, 32'h0000_01C0, 1'b1, 32'h8000_0000};
        vecs[3]  = '{64,  2, 32'h0000_0200, 1'b0, 32'h0};
        vecs[4]  = '{1,   1, 32'h0000_0008, 1'b1, 32'h0};
        vecs[5]  = '{4,   1, 32'h0000_0020, 1'b1, 32'h0};
        vecs[6]  = '{60,  2, 32'h0000_01E0, 1'b0, 32'h0};
        vecs[7]  = '{63,  2, 32'h0000_01F8, 1'b0, 32'h0};
        vecs[8]  = '{119, 2, 32'h0000_03B8, 1'b0, 32'h0};
        vecs[9]  = '{120, 3, 32'h0000_03C0, 1'b0, 32'h0};
        vecs[10] = '{128, 3, 32'h0000_0400, 1'b0, 32'h0};

        abc_blk = '0;
        abc_blk[511:480] = 32'h6162_6380;
        abc_blk[31:0]    = 32'h0000_0018;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.in_nbytes = 2'd0;
        mready_mode = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // "abc": PAD cycle, then M_v two cycles after the transfer
        send_word(32'h6162_6300, 1'b1, 2'd3);
        @(negedge clk);
        chk_b("abc_pad_cycle_M_v", bus.M_v, 1'b0);
        @(negedge clk);
        chk_b("abc_M_v_latency", bus.M_v, 1'b1);
        chk("abc_data", bus.M, abc_blk);
        chk_b("abc_M_first", bus.M_first, 1'b1);
        chk_b("abc_M_last", bus.M_last, 1'b1);
        collect(1, blks);
        $display("abc block collected, count=%0d", blks.size());

        for (int i = 0; i < 11; i++) begin
            rand_msg(vecs[i].len, msg);
            run_msg(msg, 1'b0, blks);
            chk32($sformatf("tbl_len%0d_nblocks", vecs[i].len), 32'(blks.size()), 32'(vecs[i].exp_blocks));
            if (blks.size() > 0) begin
                chk32($sformatf("tbl_len%0d_last_w15", vecs[i].len), blks[blks.size()-1].m[31:0], vecs[i].exp_w15);
                if (vecs[i].chk_w14)
                    chk32($sformatf("tbl_len%0d_blk0_w14", vecs[i].len), blks[0].m[63:32], vecs[i].exp_w14);
            end
        end

        // Backpressure: hold M_ready low for 10 EMIT cycles while in_valid is asserted
        mready_mode = 2;
        send_word(32'h6162_6300, 1'b1, 2'd3);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        bus.in_data  = $urandom;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.M_v && (waited < 10));
        chk_b("bp_M_v_rise", bus.M_v, 1'b1);
        cap = {bus.M, bus.M_first, bus.M_last};
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (({bus.M, bus.M_first, bus.M_last} !== cap) || !bus.M_v || bus.in_ready) stable = 1'b0;
        end
        chk_b("bp_hold_stable", stable, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        mready_mode = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_b("bp_after_in_ready", bus.in_ready, 1'b1);
        chk_b("bp_after_M_v", bus.M_v, 1'b0);
        collect(1, blks);
        if (blks.size() > 0) begin
            chk("bp_data", blks[0].m, abc_blk);
            chk_b("bp_first", blks[0].first, 1'b1);
            chk_b("bp_last", blks[0].last, 1'b1);
        end
        $display("backpressure block transferred, count=%0d", blks.size());

        // Reset after 7 words of a longer message, then "abc" again
        rand_msg(64, msg);
        for (int w = 0; w < 7; w++)
            send_word({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}, 1'b0, 2'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        send_word(32'h6162_6300, 1'b1, 2'd3);
        collect(1, blks);
        if (blks.size() > 0) begin
            chk("midrst_abc_data", blks[0].m, abc_blk);
            chk_b("midrst_abc_first", blks[0].first, 1'b1);
            chk_b("midrst_abc_last", blks[0].last, 1'b1);
        end
        $display("post-reset abc collected, count=%0d", blks.size());

        // Random messages with input gaps and random M_ready
        mready_mode = 1;
        for (int r = 0; r < 25; r++) begin
            rand_msg($urandom_range(1, 160), msg);
            run_msg(msg, 1'b1, blks);
        end
        mready_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
